// File: rtl/mul_issue_ctrl_if.sv
// mul_issue_ctrl_if: request, multiplier and result signal bundle for mul_issue_ctrl.
// The slave modport is the controller's view; the master modport is the
// surrounding environment (issue logic, multiplier datapath and consumer).
interface mul_issue_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;

  logic             mul_start;
  logic [2:0]       mul_ctrl;
  logic [XLEN-1:0]  mul_a;
  logic [XLEN-1:0]  mul_b;
  logic [XLEN-1:0]  mul_out;
  logic             mul_done;

  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_data;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_tag,
    output in_ready,
    output mul_start, mul_ctrl, mul_a, mul_b,
    input  mul_out, mul_done,
    output out_valid, out_data, out_tag,
    input  out_ready
  );

  modport master (
    output in_valid, in_op, in_a, in_b, in_tag,
    input  in_ready,
    input  mul_start, mul_ctrl, mul_a, mul_b,
    output mul_out, mul_done,
    input  out_valid, out_data, out_tag,
    output out_ready
  );

endinterface

// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: issue/tracking/result-buffer controller for the two-stage
// pipelined multiplier. The multiplier cannot stall, so requests are only
// accepted while the result FIFO has a free slot for every op in flight.
// Optional feature: define MUL_BYPASS_EN to forward a completing result
// straight to the output when the FIFO is empty (latency 2 instead of 3).
module mul_issue_ctrl #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  output logic            busy,
  mul_issue_ctrl_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  logic [1:0]            alive;
  logic [1:0][TAG_W-1:0] tagp;

  logic [XLEN-1:0]  data_mem [DEPTH];
  logic [TAG_W-1:0] tag_mem  [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic [OCC_W-1:0] occupancy;
  logic             issue;
  logic             done_hit;
  logic             fifo_valid;
  logic             bypass_fire;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Credit check: buffered results plus ops still in the multiplier must leave room.
  always_comb begin
    occupancy     = OCC_W'(count) + OCC_W'(alive[0]) + OCC_W'(alive[1]);
    bus.in_ready  = ~rst & ~flush & (occupancy < DEPTH_OCC);
    issue         = bus.in_valid & bus.in_ready;
    bus.mul_start = issue;
    bus.mul_ctrl  = bus.in_op;
    bus.mul_a     = bus.in_a;
    bus.mul_b     = bus.in_b;
  end

  // Completion and drain: decide push/pop and what the consumer sees this cycle.
  always_comb begin
    done_hit   = bus.mul_done & alive[1];
    fifo_valid = ~rst & (count != '0);
`ifdef MUL_BYPASS_EN
    bypass_fire = ~rst & done_hit & (count == '0);
`else
    bypass_fire = 1'b0;
`endif
    bus.out_valid = fifo_valid | bypass_fire;
    bus.out_data  = '0;
    bus.out_tag   = '0;
    if (fifo_valid) begin
      bus.out_data = data_mem[rd_ptr];
      bus.out_tag  = tag_mem[rd_ptr];
    end
`ifdef MUL_BYPASS_EN
    else if (bypass_fire) begin
      bus.out_data = bus.mul_out;
      bus.out_tag  = tagp[1];
    end
`endif
    pop  = fifo_valid & bus.out_ready;
    push = done_hit & ~(bypass_fire & bus.out_ready);
  end

  // Liveness shift register mirrors the multiplier pipeline; flush/reset kill it.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      alive <= '0;
    end else begin
      alive <= {alive[0], issue};
    end
  end

  // Tags travel alongside the liveness bits; their value only matters when alive.
  always_ff @(posedge clk) begin
    tagp <= {tagp[0], bus.in_tag};
  end

  // Result storage; contents are only observed through count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= bus.mul_out;
      tag_mem[wr_ptr]  <= tagp[1];
    end
  end

  // FIFO pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign busy = ~rst & ((|alive) | (count != '0));

endmodule

// File: doc/mul_issue_ctrl.md
# mul_issue_ctrl

- Sits in EX between the issue logic and the two-stage pipelined Wallace multiplier.
- Accepts multiply requests over a valid/ready handshake and drives the multiplier's start, operand and control inputs.
- Tracks in-flight operations with a tag pipeline and buffers results in a credit-protected FIFO, because the multiplier pipeline cannot stall.
- Supports flush for branch/exception recovery.

## Interface
- XLEN, 32: operand/result width. The multiplier is fixed at 32.
- TAG_W, 5: destination tag width.
- DEPTH, 4: result FIFO entries. Minimum 2; full throughput with a stalled-free consumer requires ≥4.

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- in_op  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; 1xx never presented
- in_a, in_b  in  XLEN  rs1 (multiplicand), rs2 (multiplier)
- in_tag  in  TAG_W  destination tag
- flush  in  1  kill all in-flight and buffered ops
- mul_start  out  1  issue pulse to multiplier
- mul_ctrl  out  3  = in_op
- mul_a, mul_b  out  XLEN  = in_a, in_b (pass-through)
- mul_out  in  XLEN  multiplier result
- mul_done  in  1  multiplier done pulse, 2 cycles after mul_start
- out_valid  out  1  result valid
- out_ready  in  1  consumer ready
- out_data  out  XLEN  result
- out_tag  out  TAG_W  tag of result
- busy  out  1  any op in flight or buffered

## Operation
**State**
- alive[1:0] is a shift register, with a tag pipe tagp[1:0] shifted in parallel.
- FIFO of {tag, data} with wr_ptr, rd_ptr (mod DEPTH) and count (0..DEPTH).

**Issue**
- in_ready = ~rst & ~flush & (count + alive[0] + alive[1] < DEPTH).
- mul_start = in_valid & in_ready.
- alive[0] <= mul_start, tagp[0] <= in_tag, alive[1] <= alive[0], tagp[1] <= tagp[0].

**Completion**
- When mul_done & alive[1], push {tagp[1], mul_out}.
- mul_done with alive[1]=0 (killed op) is ignored.
- Verification asserts mul_done == the registered value of alive[1] whenever no flush or reset occurred in the preceding two cycles.

**Drain**
- out_valid = (count != 0); head entry drives out_data/out_tag.
- Pop on out_valid & out_ready.

**Ordering and overflow**
- Credits guarantee a push never hits a full FIFO, including a simultaneous push and pop.
- Results leave in issue order.

**Flush**
- At the edge: alive, count and both pointers are cleared.
- Same cycle: in_ready=0 and no issue. out_valid still reflects pre-flush state, and a handshake in that cycle completes.

**Reset**
- Clears the same state as flush.
- Outputs while and after reset: in_ready=0 while rst=1; mul_start=0; out_valid=0; busy=0; out_data/out_tag = 0.

**Other**
- busy = |alive | (count != 0).
- The multiplier's own async reset is driven by the top, not by this block. Stale mul_done after rst is masked by alive=0.

## Timing
- Accept at cycle t. mul_done and mul_out are valid at t+2.
- Push at the end of t+2; out_valid at t+3 (no bypass).
- Steady state with out_ready=1: 1 op/cycle for DEPTH≥4.
- With out_ready=0: exactly DEPTH ops accepted, then in_ready=0 until a pop.
- Each pop raises in_ready in the next cycle.

## Configuration
**MUL_BYPASS_EN defined**
- When count==0 and mul_done & alive[1], out_valid is asserted combinationally at t+2 with out_data=mul_out and out_tag=tagp[1].
- If out_ready=1 in that cycle, no push occurs; otherwise the result is pushed.
- Latency becomes 2.

**Undefined**
- out_valid comes only from FIFO state; latency is 3.
- No combinational path from mul_done to out_valid.

## Test plan
- MUL 7×6, tag 3, out_ready=1 → out_valid at t+3 (t+2 with bypass), out_data=42, out_tag=3, busy low the cycle after.
- MULH 0xFFFFFFFF×0xFFFFFFFF → 0x00000000.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- MULHSU 0xFFFFFFFE×0xFFFFFFFF → 0xFFFFFFFE.
- 10 back-to-back ops, out_ready=0 → exactly 4 accepted, in_ready=0 afterwards. Then out_ready=1 → results drain in order with tags 0..3, and issue resumes one cycle after the first pop.
- Streaming 20 ops with out_ready=1 → in_ready never drops, one result per cycle.
- Flush at t+1 after two issues, with FIFO holding 1 entry → next cycle out_valid=0 and busy=0. The later mul_done pulses produce no output. A new MUL 3×5 then returns 15.
- Assert rst for 1 cycle with 2 ops in flight → in_ready=0 during rst, no outputs from the killed ops, clean operation afterwards.
